// File: rtl/spi_periph_master.sv
// rtl/spi_periph_master.sv - SPI mode-0 initiator for on-board peripherals
// Purpose: serialises one WIDTH-bit word per transaction, MSB first. The shared
//   active-low chip selects are masked by a latched select vector.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           transaction request, sampled only while idle
//   tx_data, cs_sel word and CS mask, latched when start is accepted
//   busy, done      transaction in progress; 1-cycle end pulse
//   rx_data         captured miso word (constant 0 without readback)
//   sclk, mosi      SPI clock (idle low) and data out, registered
//   miso            SPI data in
//   cs_n            active-low chip selects, registered
// Optional feature macro: SPI_MASTER_READBACK_EN enables miso capture into rx_data.
module spi_periph_master #(
  parameter int WIDTH    = 24,
  parameter int CLKDIV   = 4,
  parameter int CS_GUARD = 2,
  parameter int NCS      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic [NCS-1:0]   cs_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic [NCS-1:0]   cs_n
);

  localparam int CMAX = (2 * CLKDIV > CS_GUARD) ? 2 * CLKDIV : CS_GUARD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] GUARD_LAST  = CW'(CS_GUARD - 1);
  localparam logic [CW-1:0] HALF_LAST   = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(2 * CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] tx_shift;
  logic             guard_end, half_end, period_end, last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // busy is high exactly when state != IDLE, so testing start in IDLE
  // is the same as sampling start with busy=0.
  always_comb begin
    state_next = state;
    guard_end  = (cnt == GUARD_LAST);
    half_end   = (cnt == HALF_LAST);
    period_end = (cnt == PERIOD_LAST);
    last_bit   = (bit_idx == BIT_LAST);
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (guard_end) state_next = SHIFT;
      SHIFT:   if (period_end && last_bit) state_next = HOLD;
      HOLD:    if (guard_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      cnt      <= '0;
      bit_idx  <= '0;
      tx_shift <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            cs_n     <= ~cs_sel;
            tx_shift <= tx_data;
            mosi     <= tx_data[WIDTH-1];
            cnt      <= '0;
            bit_idx  <= '0;
          end
        end
        SETUP: cnt <= guard_end ? '0 : cnt + CW'(1);
        SHIFT: begin
          // Bit period: low for CLKDIV cycles, high for CLKDIV cycles.
          if (half_end) sclk <= 1'b1;
          if (period_end) begin
            cnt  <= '0;
            sclk <= 1'b0;
            if (!last_bit) begin
              bit_idx  <= bit_idx + BW'(1);
              mosi     <= tx_shift[WIDTH-2];
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (guard_end) begin
            cnt  <= '0;
            cs_n <= '1;
            busy <= 1'b0;
            done <= 1'b1;
            mosi <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_MASTER_READBACK_EN
  logic [WIDTH-1:0] rx_shift;

  // miso is sampled on the edge that raises sclk; every transaction shifts
  // in all WIDTH bits, so the register never needs clearing between words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      if (state == SHIFT && half_end) rx_shift <= {rx_shift[WIDTH-2:0], miso};
      if (state == HOLD && guard_end) rx_data <= rx_shift;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_periph_master.sv
// tb/tb_spi_periph_master.sv - directed self-checking bench for spi_periph_master
module tb_spi_periph_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [23:0] tx_data = '0;
  logic [7:0]  cs_sel = '0;
  logic        busy, done, sclk, mosi;
  logic        miso = 1'b0;
  logic [23:0] rx_data;
  logic [7:0]  cs_n;

  int checks = 0;
  int failures = 0;

  spi_periph_master #(.WIDTH(24), .CLKDIV(4), .CS_GUARD(2), .NCS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  // Measurements from the last transfer
  int          bc, rises, first_low, done_cnt;
  bit          pulse_ok, cs_const, timeout;
  logic [23:0] mosi_word, rx_at, swreg;
  logic [7:0]  cs_first, csn_after;

  // Launches (unless skip) and observes one transfer on falling edges, acting as a
  // mode-0 slave on miso. inject>0: at busy cycle inject, pulse start with alt_tx and
  // a new cs_sel. hold: keep start high and switch tx_data to alt_tx during busy.
  task automatic do_xfer(input logic [23:0] tx, input logic [7:0] sel, input logic [23:0] sw,
                         input int inject, input bit hold, input bit skip,
                         input logic [23:0] alt_tx);
    logic psclk;
    int   run_len;
    bc = 0; rises = 0; first_low = 0; done_cnt = 0; pulse_ok = 1; cs_const = 1;
    timeout = 1; mosi_word = '0; rx_at = '0; cs_first = 'x; csn_after = 'x;
    psclk = 1'b0; run_len = 0;
    if (!skip) begin
      start = 1'b1; tx_data = tx; cs_sel = sel;
    end
    swreg = sw; miso = sw[23];
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!busy) begin
        rx_at = rx_data; csn_after = cs_n;
        if (done) done_cnt++;
        timeout = 0;
        break;
      end
      bc++;
      if (bc == 1) cs_first = cs_n;
      else if (cs_n !== cs_first) cs_const = 0;
      if (done) done_cnt++;
      if (rises == 0 && !sclk) first_low++;
      if (sclk !== psclk) begin
        if (psclk && run_len != 4) pulse_ok = 0;
        if (!psclk && rises > 0 && run_len != 4) pulse_ok = 0;
        if (sclk) begin
          rises++; mosi_word = {mosi_word[22:0], mosi};
        end else begin
          swreg = {swreg[22:0], 1'b0}; miso = swreg[23];
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      if (inject > 0 && bc == inject) begin
        start = 1'b1; tx_data = alt_tx; cs_sel = 8'hFF;
      end else if (inject > 0 && bc == inject + 1) begin
        start = 1'b0;
      end
      if (hold && bc == 1) tx_data = alt_tx;
      psclk = sclk;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cs_n !== 8'hFF || sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || rx_data !== 24'h0) begin
      failures++;
      $display("FAIL reset_state: cs_n=%h sclk=%b mosi=%b busy=%b done=%b rx=%h required FF/0/0/0/0/0",
               cs_n, sclk, mosi, busy, done, rx_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cs_n !== 8'hFF) begin
      failures++;
      $display("FAIL reset_idle: busy=%b cs_n=%h required 0/FF", busy, cs_n);
    end
  endtask

  task automatic test_basic(input logic [23:0] tx, input logic [7:0] sel, input logic [7:0] exp_cs,
                            input logic [23:0] sw, input string name);
    logic [23:0] exp_rx;
`ifdef SPI_MASTER_READBACK_EN
    exp_rx = sw;
`else
    exp_rx = 24'h0;
`endif
    do_xfer(tx, sel, sw, 0, 0, 0, 24'h0);
    checks++;
    if (timeout) begin failures++; $display("FAIL %s_timeout: busy never fell", name); end
    checks++;
    if (bc != 196) begin failures++; $display("FAIL %s_busy_len: got %0d required 196", name, bc); end
    checks++;
    if (rises != 24) begin failures++; $display("FAIL %s_sclk_pulses: got %0d required 24", name, rises); end
    checks++;
    if (!pulse_ok) begin failures++; $display("FAIL %s_sclk_shape: got irregular required 4 high/4 low", name); end
    checks++;
    if (first_low != 6) begin failures++; $display("FAIL %s_first_rise: got %0d required 6", name, first_low); end
    checks++;
    if (mosi_word !== tx) begin failures++; $display("FAIL %s_mosi: got %h required %h", name, mosi_word, tx); end
    checks++;
    if (cs_first !== exp_cs || !cs_const) begin
      failures++; $display("FAIL %s_cs_n: got %h const=%0d required %h const", name, cs_first, cs_const, exp_cs);
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL %s_done: got %0d pulses required 1", name, done_cnt); end
    checks++;
    if (csn_after !== 8'hFF) begin failures++; $display("FAIL %s_cs_release: got %h required FF", name, csn_after); end
    checks++;
    if (rx_at !== exp_rx) begin failures++; $display("FAIL %s_rx_data: got %h required %h", name, rx_at, exp_rx); end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_data !== exp_rx || done !== 1'b0) begin
      failures++; $display("FAIL %s_rx_hold: got %h done=%b required %h done=0", name, rx_data, done, exp_rx);
    end
  endtask

  task automatic test_start_during_busy;
    int extra_done;
    do_xfer(24'hA5C30F, 8'h02, 24'h0, 50, 0, 0, 24'hFFFFFF);
    extra_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_done += 100;
    end
    checks++;
    if (mosi_word !== 24'hA5C30F) begin failures++; $display("FAIL busy_start_mosi: got %h required A5C30F", mosi_word); end
    checks++;
    if (done_cnt + extra_done != 1) begin
      failures++; $display("FAIL busy_start_done: got %0d required 1", done_cnt + extra_done);
    end
    checks++;
    if (cs_first !== 8'hFD || !cs_const || bc != 196) begin
      failures++; $display("FAIL busy_start_cs: got %h const=%0d len=%0d required FD const 196", cs_first, cs_const, bc);
    end
  endtask

  task automatic test_back_to_back;
    do_xfer(24'h123456, 8'h01, 24'h0, 0, 1, 0, 24'h89ABCD);
    checks++;
    if (mosi_word !== 24'h123456 || bc != 196) begin
      failures++; $display("FAIL b2b_first: got %h len=%0d required 123456 196", mosi_word, bc);
    end
    checks++;
    if (csn_after !== 8'hFF || done_cnt != 1) begin
      failures++; $display("FAIL b2b_gap: got cs_n=%h done=%0d required FF 1", csn_after, done_cnt);
    end
    do_xfer(24'h0, 8'h0, 24'h0, 0, 0, 1, 24'h0);
    checks++;
    if (bc != 196 || cs_first !== 8'hFE) begin
      failures++; $display("FAIL b2b_restart: got len=%0d cs_n=%h required 196 FE", bc, cs_first);
    end
    checks++;
    if (mosi_word !== 24'h89ABCD) begin failures++; $display("FAIL b2b_second_mosi: got %h required 89ABCD", mosi_word); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_shift;
    bit   seen;
    logic psclk;
    int   r;
    start = 1'b1; tx_data = 24'hFFFFFF; cs_sel = 8'h10;
    @(negedge clk);
    start = 1'b0;
    seen = 0; r = 0; psclk = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (sclk && !psclk) r++;
      psclk = sclk;
      if (r == 11) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midrst_reach: got %0d rises required 11", r); end
    rst = 1'b1;
    #1;
    checks++;
    if (cs_n !== 8'hFF || sclk !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_now: cs_n=%h sclk=%b busy=%b required FF/0/0", cs_n, sclk, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || sclk || cs_n !== 8'hFF || done) seen = 1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL midrst_idle: got activity required idle"); end
  endtask

  initial begin
    test_reset();
    test_basic(24'hA5C30F, 8'h02, 8'hFD, 24'h3C5A96, "basic");
    test_basic(24'h000001, 8'h00, 8'hFF, 24'hC00003, "sel_zero");
    test_basic(24'h800000, 8'h05, 8'hFA, 24'h5A5A5A, "sel_multi");
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid_shift();
    test_basic(24'h5AF00F, 8'h80, 8'h7F, 24'hFFFFFF, "after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
